// File: rtl/aes_chain_pkg.sv
// Shared types and helpers for the multi-block AES mode controller.
package aes_chain_pkg;

  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {
    MODE_ECB = 2'b00,
    MODE_CBC = 2'b01,
    MODE_CTR = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  // Block captured at the input handshake; drives the whole transaction.
  typedef struct packed {
    logic [BLK_W-1:0] block;
    logic             last;
    mode_e            mode;
    logic             encdec;
  } blk_req_t;

  // The reserved encoding falls back to ECB.
  function automatic mode_e mode_decode(input logic [1:0] m);
    mode_e res;
    case (m)
      2'b01:   res = MODE_CBC;
      2'b10:   res = MODE_CTR;
      default: res = MODE_ECB;
    endcase
    return res;
  endfunction

  // Increment only the low 'width' bits; upper bits untouched, no carry out.
  function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] cb,
                                               input int unsigned      width);
    logic [BLK_W-1:0] mask;
    mask = (width >= BLK_W) ? '1 : ((BLK_W'(1) << width) - BLK_W'(1));
    return (cb & ~mask) | ((cb + BLK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes_chain_ctrl_if.sv
// Streaming block interface between the SE front-end (master) and the controller (slave).
interface aes_chain_ctrl_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [aes_chain_pkg::BLK_W-1:0]   in_block;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [aes_chain_pkg::BLK_W-1:0]   out_block;
  logic                              out_last;

  modport master (
    output in_valid, in_block, in_last, out_ready,
    input  in_ready, out_valid, out_block, out_last
  );

  modport slave (
    input  in_valid, in_block, in_last, out_ready,
    output in_ready, out_valid, out_block, out_last
  );

endinterface

// File: rtl/aes_chain_out_reg.sv
// Result holding register: keeps block/last stable under backpressure until taken.
module aes_chain_out_reg
  import aes_chain_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BLK_W-1:0] load_block,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [BLK_W-1:0] block,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      block <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      block <= load_block;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_chain_ctrl.sv
// ECB/CBC/CTR chaining controller around a single-block AES engine.
// Optional AES_CHAIN_BLKCNT_EN adds a delivered-block counter output.
module aes_chain_ctrl
  import aes_chain_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = 32,
  parameter int unsigned KEY_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic                 encdec,
  input  logic                 keylen,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 key_init,
  input  logic [BLK_W-1:0]     iv,
  input  logic                 iv_load,
  aes_chain_ctrl_if.slave      strm,
  output logic                 busy,
  output logic                 key_valid,
  output logic                 eng_init,
  output logic                 eng_next,
  output logic                 eng_encdec,
  output logic [BLK_W-1:0]     eng_block,
  input  logic                 eng_ready,
  input  logic [BLK_W-1:0]     eng_result,
  input  logic                 eng_result_valid
`ifdef AES_CHAIN_BLKCNT_EN
  ,
  output logic [31:0]          blk_count
`endif
);

  state_e           state, state_d;
  blk_req_t         req, req_d;
  logic [BLK_W-1:0] cv, cv_d;
  logic [BLK_W-1:0] eng_block_d;
  logic             eng_encdec_d, eng_init_d, eng_next_d;
  logic             key_valid_d, busy_d;
  logic             out_load;
  logic [BLK_W-1:0] out_data;
  logic             in_fire;
  mode_e            mode_sel;

  // Key and key length go to the engine directly at integration level.
  logic unused_cfg;
  assign unused_cfg = ^{keylen, key};

  assign mode_sel      = mode_decode(mode);
  assign strm.in_ready = (state == S_IDLE) && key_valid && !key_init && !iv_load;
  assign in_fire       = strm.in_valid && strm.in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      req        <= '0;
      cv         <= '0;
      eng_block  <= '0;
      eng_encdec <= 1'b0;
      eng_init   <= 1'b0;
      eng_next   <= 1'b0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      req        <= req_d;
      cv         <= cv_d;
      eng_block  <= eng_block_d;
      eng_encdec <= eng_encdec_d;
      eng_init   <= eng_init_d;
      eng_next   <= eng_next_d;
      key_valid  <= key_valid_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state;
    req_d        = req;
    cv_d         = cv;
    eng_block_d  = eng_block;
    eng_encdec_d = eng_encdec;
    eng_init_d   = 1'b0;
    eng_next_d   = 1'b0;
    key_valid_d  = key_valid;
    out_load     = 1'b0;
    out_data     = eng_result;

    unique case (state)
      S_IDLE: begin
        if (key_init) begin
          eng_init_d  = 1'b1;
          key_valid_d = 1'b0;
          state_d     = S_KEY;
        end else if (iv_load) begin
          cv_d = iv;
        end else if (in_fire) begin
          req_d.block  = strm.in_block;
          req_d.last   = strm.in_last;
          req_d.mode   = mode_sel;
          req_d.encdec = encdec;
          eng_encdec_d = (mode_sel == MODE_CTR) ? 1'b1 : encdec;
          case (mode_sel)
            MODE_CTR: eng_block_d = cv;
            MODE_CBC: eng_block_d = encdec ? (strm.in_block ^ cv) : strm.in_block;
            default:  eng_block_d = strm.in_block;
          endcase
          eng_next_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      // eng_init is still high on the first key cycle; ready there is stale.
      S_KEY: begin
        if (!eng_init && eng_ready) begin
          key_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_result_valid) begin
          out_load = 1'b1;
          state_d  = S_OUT;
          case (req.mode)
            MODE_CBC: begin
              if (req.encdec) begin
                cv_d = eng_result;
              end else begin
                out_data = eng_result ^ cv;
                cv_d     = req.block;
              end
            end
            MODE_CTR: begin
              out_data = eng_result ^ req.block;
              cv_d     = ctr_inc(cv, CTR_WIDTH);
            end
            default: ;
          endcase
        end
      end
      S_OUT: begin
        if (strm.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  aes_chain_out_reg u_out_reg (
    .clk        (clk),
    .rst_n      (reset_n),
    .load       (out_load),
    .load_block (out_data),
    .load_last  (req.last),
    .ready      (strm.out_ready),
    .valid      (strm.out_valid),
    .block      (strm.out_block),
    .last       (strm.out_last)
  );

`ifdef AES_CHAIN_BLKCNT_EN
  // Counts delivered blocks; restarts with each new key or IV.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_count <= '0;
    end else if ((state == S_IDLE) && (key_init || iv_load)) begin
      blk_count <= '0;
    end else if (strm.out_valid && strm.out_ready) begin
      blk_count <= blk_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_chain_ctrl.sv
// Directed bench for aes_chain_ctrl with a table-driven AES engine stand-in.
module tb_aes_chain_ctrl;
  import aes_chain_pkg::*;

  localparam logic [127:0] ECB_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ECB_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ECB_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CBC_IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1      = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1      = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2      = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CTR_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] CTR_KS  = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] CTR_C1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] WRAP_IV = 128'h0123456789abcdef01234567ffffffff;
  localparam logic [127:0] WRAP_1  = 128'h0123456789abcdef0123456700000000;
  localparam logic [127:0] WRAP_2  = 128'h0123456789abcdef0123456700000001;
  localparam logic [127:0] D1      = 128'h00000000111111112222222233333333;
  localparam logic [127:0] D2      = 128'h44444444555555556666666677777777;
  localparam logic [127:0] D3      = 128'h8888888899999999aaaaaaaabbbbbbbb;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   mode;
  logic         encdec, keylen, key_init, iv_load;
  logic [255:0] key;
  logic [127:0] iv;
  logic         busy, key_valid, eng_init, eng_next, eng_encdec;
  logic [127:0] eng_block, eng_result;
  logic         eng_ready, eng_result_valid;
`ifdef AES_CHAIN_BLKCNT_EN
  logic [31:0]  blk_count;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  aes_chain_ctrl_if strm ();

  aes_chain_ctrl #(.CTR_WIDTH(32), .KEY_WIDTH(256)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mode             (mode),
    .encdec           (encdec),
    .keylen           (keylen),
    .key              (key),
    .key_init         (key_init),
    .iv               (iv),
    .iv_load          (iv_load),
    .strm             (strm),
    .busy             (busy),
    .key_valid        (key_valid),
    .eng_init         (eng_init),
    .eng_next         (eng_next),
    .eng_encdec       (eng_encdec),
    .eng_block        (eng_block),
    .eng_ready        (eng_ready),
    .eng_result       (eng_result),
    .eng_result_valid (eng_result_valid)
`ifdef AES_CHAIN_BLKCNT_EN
    ,
    .blk_count        (blk_count)
`endif
  );

  always #5 clk = ~clk;

  // Engine stand-in: known AES pairs from the test vectors, bitwise NOT otherwise.
  function automatic logic [127:0] eng_fn(input logic [127:0] x, input logic enc);
    logic [127:0] pt [4];
    logic [127:0] ct [4];
    pt[0] = ECB_PT;      ct[0] = ECB_CT;
    pt[1] = P1 ^ CBC_IV; ct[1] = C1;
    pt[2] = P2 ^ C1;     ct[2] = C2;
    pt[3] = CTR_IV;      ct[3] = CTR_KS;
    for (int i = 0; i < 4; i++) begin
      if (enc && (x === pt[i])) return ct[i];
      if (!enc && (x === ct[i])) return pt[i];
    end
    return ~x;
  endfunction

  int unsigned  eng_cnt;
  logic         eng_pend, eng_dir;
  logic [127:0] eng_in;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_ready <= 1'b1; eng_result_valid <= 1'b0; eng_result <= '0;
      eng_cnt <= 0; eng_pend <= 1'b0; eng_dir <= 1'b0; eng_in <= '0;
    end else if (eng_init) begin
      eng_ready <= 1'b0; eng_result_valid <= 1'b0; eng_cnt <= 4; eng_pend <= 1'b0;
    end else if (eng_next) begin
      eng_ready <= 1'b0; eng_result_valid <= 1'b0; eng_cnt <= 3; eng_pend <= 1'b1;
      eng_in <= eng_block; eng_dir <= eng_encdec;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_ready <= 1'b1;
        if (eng_pend) begin
          eng_result_valid <= 1'b1;
          eng_result <= eng_fn(eng_in, eng_dir);
          eng_pend <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_key();
    int n;
    n = 0;
    while (!key_valid && n < 30) begin tick(); n++; end
    chk("key_valid_set", key_valid, 1);
  endtask

  task automatic do_key_init();
    key_init = 1'b1;
    tick();
    key_init = 1'b0;
    chk("key_init_pulse", {eng_init, key_valid, busy}, 3'b101);
    tick();
    chk("key_first_cycle", {eng_init, key_valid}, 2'b00);
    wait_key();
  endtask

  task automatic do_iv(input logic [127:0] v);
    iv = v; iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
  endtask

  task automatic send_block(input logic [1:0] m, input logic ed, input logic [127:0] blk,
                            input logic lst, output logic [127:0] res, output logic res_last,
                            output logic [127:0] eblk, output logic eed);
    int n;
    mode = m; encdec = ed; strm.in_block = blk; strm.in_last = lst; strm.in_valid = 1'b1;
    #1;
    n = 0;
    while (!strm.in_ready && n < 20) begin tick(); n++; end
    chk("in_accept", strm.in_ready, 1);
    tick();
    strm.in_valid = 1'b0;
    mode = ~m; encdec = ~ed;
    chk("eng_next_hi", eng_next, 1);
    eblk = eng_block; eed = eng_encdec;
    tick();
    chk("eng_next_lo", eng_next, 0);
    n = 0;
    while (!strm.out_valid && n < 50) begin tick(); n++; end
    chk("out_valid_seen", strm.out_valid, 1);
    res = strm.out_block; res_last = strm.out_last;
    strm.out_ready = 1'b1;
    tick();
    strm.out_ready = 1'b0;
    chk("idle_after_out", {strm.out_valid, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r, eb;
    logic rl, ed;
    int n;
    reset_n = 1'b0; mode = 2'b00; encdec = 1'b0; keylen = 1'b0; key = '0;
    key_init = 1'b0; iv = '0; iv_load = 1'b0;
    strm.in_valid = 1'b0; strm.in_block = '0; strm.in_last = 1'b0; strm.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_flags", {strm.in_ready, strm.out_valid, strm.out_last, busy, key_valid,
                      eng_init, eng_next, eng_encdec}, 8'h00);
    chk("rst_out_block", strm.out_block, '0);
    chk("rst_eng_block", eng_block, '0);
    reset_n = 1'b1;
    tick();

    // Blocks offered before any key expansion are never taken.
    strm.in_valid = 1'b1; strm.in_block = ECB_PT;
    repeat (5) begin #1; chk("nokey_not_taken", {strm.in_ready, busy}, 2'b00); tick(); end
    strm.in_valid = 1'b0;

    key = {128'h0, ECB_KEY};
    do_key_init();
    send_block(2'b00, 1'b1, ECB_PT, 1'b0, r, rl, eb, ed);
    chk("ecb_enc", r, ECB_CT);
    chk("ecb_enc_eng_blk", eb, ECB_PT);
    send_block(2'b00, 1'b0, ECB_CT, 1'b0, r, rl, eb, ed);
    chk("ecb_dec", r, ECB_PT);
    chk("ecb_dec_dir", ed, 0);
    send_block(2'b11, 1'b1, ECB_PT, 1'b1, r, rl, eb, ed);
    chk("rsvd_as_ecb", r, ECB_CT);
    chk("rsvd_last", rl, 1);

    key = {128'h0, K2};
    do_key_init();
    do_iv(CBC_IV);
    send_block(2'b01, 1'b1, P1, 1'b0, r, rl, eb, ed);
    chk("cbc_enc_1", r, C1);
    chk("cbc_enc_1_last", rl, 0);
    send_block(2'b01, 1'b1, P2, 1'b1, r, rl, eb, ed);
    chk("cbc_enc_2", r, C2);
    chk("cbc_enc_2_last", rl, 1);
    do_iv(CBC_IV);
    send_block(2'b01, 1'b0, C1, 1'b0, r, rl, eb, ed);
    chk("cbc_dec_1", r, P1);
    send_block(2'b01, 1'b0, C2, 1'b1, r, rl, eb, ed);
    chk("cbc_dec_2", r, P2);

    do_iv(CTR_IV);
    send_block(2'b10, 1'b0, P1, 1'b1, r, rl, eb, ed);
    chk("ctr_f51", r, CTR_C1);
    chk("ctr_dir_forced", ed, 1);
    chk("ctr_eng_blk", eb, CTR_IV);

    // Low word wraps to zero, upper 96 bits keep their value.
    do_iv(WRAP_IV);
    send_block(2'b10, 1'b1, D1, 1'b0, r, rl, eb, ed);
    chk("wrap_eng_blk_0", eb, WRAP_IV);
    chk("wrap_out_0", r, ~WRAP_IV ^ D1);
    send_block(2'b10, 1'b1, D2, 1'b1, r, rl, eb, ed);
    chk("wrap_eng_blk_1", eb, WRAP_1);
    chk("wrap_out_1", r, ~WRAP_1 ^ D2);

    // key_init wins over iv_load and in_valid; the IV must not land.
    key_init = 1'b1; iv_load = 1'b1; iv = {4{32'h55555555}};
    strm.in_valid = 1'b1; strm.in_block = D3;
    #1;
    chk("prio_in_ready", strm.in_ready, 0);
    tick();
    key_init = 1'b0; iv_load = 1'b0; strm.in_valid = 1'b0;
    chk("prio_key_only", {eng_init, key_valid, busy, eng_next}, 4'b1010);
    wait_key();
    send_block(2'b10, 1'b1, D3, 1'b0, r, rl, eb, ed);
    chk("prio_cv_kept", eb, WRAP_2);
    chk("prio_ctr_out", r, ~WRAP_2 ^ D3);

    // Backpressure: result held stable, nothing new accepted.
    key = {128'h0, ECB_KEY};
    do_key_init();
    mode = 2'b00; encdec = 1'b1; strm.in_block = ECB_PT; strm.in_last = 1'b1; strm.in_valid = 1'b1;
    #1;
    chk("bp_in_ready", strm.in_ready, 1);
    tick();
    strm.in_block = ECB_CT;
    n = 0;
    while (!strm.out_valid && n < 50) begin tick(); n++; end
    chk("bp_out_valid", strm.out_valid, 1);
    repeat (10) begin
      chk("bp_hold_flags", {strm.out_valid, strm.out_last, strm.in_ready, busy}, 4'b1101);
      chk("bp_hold_block", strm.out_block, ECB_CT);
      tick();
    end
    strm.in_valid = 1'b0; strm.out_ready = 1'b1;
    tick();
    strm.out_ready = 1'b0;
    chk("bp_release", {strm.out_valid, busy}, 2'b00);
    tick();
    chk("bp_single_xfer", {strm.out_valid, busy}, 2'b00);

    // Reset while waiting on the engine aborts the block.
    mode = 2'b00; encdec = 1'b1; strm.in_block = ECB_PT; strm.in_last = 1'b0; strm.in_valid = 1'b1;
    #1;
    chk("rw_in_ready", strm.in_ready, 1);
    tick();
    strm.in_valid = 1'b0;
    tick();
    chk("rw_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_flags", {strm.in_ready, strm.out_valid, strm.out_last, busy, key_valid,
                     eng_init, eng_next, eng_encdec}, 8'h00);
    chk("rw_out_block", strm.out_block, '0);
    chk("rw_eng_block", eng_block, '0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (8) tick();
    chk("rw_no_output", {strm.out_valid, busy, key_valid}, 3'b000);
    do_key_init();
    send_block(2'b00, 1'b1, ECB_PT, 1'b1, r, rl, eb, ed);
    chk("rw_ecb_after", r, ECB_CT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_chain_ctrl.md
Name: aes_chain_ctrl

Overview:
Multi-block AES mode controller wrapped around the existing single-block AES engine (init/next/ready/result_valid interface). It adds streaming valid/ready handshakes, a true chaining register updated per block, and a CTR mode. It supports ECB, CBC and CTR, and sits between the SE bus/DMA front-end and the AES engine.

Parameters:
CTR_WIDTH, 32, number of low-order bits of the counter block incremented in CTR mode (1..128).
KEY_WIDTH, 256, engine key bus width (fixed for 128/256-bit keys).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved (treated as ECB)
encdec  in  1  1 encrypt, 0 decrypt (ignored in CTR)
keylen  in  1  0 AES-128, 1 AES-256
key  in  KEY_WIDTH  cipher key
key_init  in  1  pulse: expand key
iv  in  128  IV / initial counter block
iv_load  in  1  pulse: chain register <= iv
in_valid  in  1  input block valid
in_ready  out  1  controller accepts block
in_block  in  128  plaintext/ciphertext
in_last  in  1  marks final block of message
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
out_block  out  128  result block
out_last  out  1  copy of accepted in_last
busy  out  1  not in S_IDLE
key_valid  out  1  key expanded and usable
eng_init  out  1  engine key-init pulse
eng_next  out  1  engine block-start pulse
eng_encdec  out  1  engine direction
eng_block  out  128  engine input block
eng_ready  in  1  engine ready
eng_result  in  128  engine output
eng_result_valid  in  1  engine result valid

Behaviour:
- Reset: all outputs 0; chain register (CV) 0; key_valid 0; state S_IDLE. Reset is honoured in any state and aborts in-flight work; no output is produced for an aborted block.
- States: S_IDLE, S_KEY, S_ISSUE, S_WAIT, S_OUT.
- S_IDLE priority: key_init > iv_load > in_valid.
  - key_init: eng_init=1 for 1 cycle; key_valid<=0; go to S_KEY.
  - iv_load: CV<=iv; stay in S_IDLE.
  - in_valid && in_ready: latch in_block, in_last, mode, encdec; go to S_ISSUE.
- in_ready=1 only in S_IDLE with key_valid=1 and key_init=0 and iv_load=0.
- S_KEY: eng_ready is ignored on the first cycle. Then wait for eng_ready=1, set key_valid<=1, and go to S_IDLE.
- S_ISSUE: eng_next=1 for exactly 1 cycle; eng_block/eng_encdec stay driven from latched data until S_OUT; go to S_WAIT.
- S_WAIT: on eng_result_valid, compute out_block, update CV, out_valid<=1, go to S_OUT.
- Datapath per latched mode:
  - ECB: eng_block=in; out=res.
  - CBC encrypt: eng_block=in^CV; out=res; CV<=res.
  - CBC decrypt: eng_block=in; out=res^CV; CV<=in.
  - CTR: eng_encdec=1; eng_block=CV; out=res^in; CV[CTR_WIDTH-1:0] increments modulo 2^CTR_WIDTH; upper bits unchanged; no carry out, no error.
- S_OUT: out_valid, out_block and out_last are held stable until out_ready=1. Go to S_IDLE on the same edge.
- Latency: from in handshake, eng_next 1 cycle later; out_valid 1 cycle after eng_result_valid. Minimum overhead is 3 cycles plus engine latency.
- After in_last, CV is retained. A new message must be preceded by iv_load (not enforced).
- key_init or iv_load outside S_IDLE is ignored.
- Mode/encdec changes outside the input handshake have no effect on the block in flight.

Optional Feature:
AES_CHAIN_BLKCNT_EN: adds output blk_count[31:0], which counts delivered output blocks (increments on out handshake). It clears on iv_load, key_init and reset, and wraps at 2^32. Without the macro, the port and counter are absent.

Decomposition:
- Package aes_chain_pkg holds:
  - Mode encodings MODE_ECB/MODE_CBC/MODE_CTR.
  - State encodings.
  - Width constant BLK_W=128.
  - CTR increment function.
- One natural sub-module: aes_chain_out_reg, the output holding register with valid/ready and last flag.

Test Plan:
- ECB AES-128: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a; decrypting it returns pt.
- CBC encrypt (SP800-38A F.2.1): key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102..0f, blocks 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 -> 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2; CBC decrypt of those ciphertexts returns the plaintexts.
- CTR (F.5.1): same key, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, p1 6bc1bee22e409f96e93d7e117393172a -> 874d6191b620e3261bef6864990db6ce. Then CV low word checked: IV low word ffffffff (CTR_WIDTH=32) -> after one block low word 00000000, upper 96 bits unchanged.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid/out_block stable and in_ready=0 throughout; release -> a single transfer and return to S_IDLE.
- Priority/guarding: key_init, iv_load and in_valid asserted together -> only key init occurs, in_ready=0. in_valid before key_valid -> never accepted.
- Reset mid S_WAIT -> all outputs 0 and key_valid=0; a subsequent key_init plus ECB vector passes.
